// File: rtl/pdm_mic_capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared types and helpers for the dual-microphone PDM capture controller.
//   pdm_state_e : controller state encoding (IDLE, WAKE, RUN)
//   DROP_CNT_W  : width of the optional dropped-pair counter
//   cnt_width() : minimum counter width able to hold 0..n-1
// -----------------------------------------------------------------------------
package pdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2
    } pdm_state_e;

    localparam int DROP_CNT_W = 16;

    // Width needed for a counter running 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        int w_v;
        if (n > 1) begin
            w_v = $clog2(n);
        end else begin
            w_v = 1;
        end
        return w_v;
    endfunction

endpackage

// File: rtl/pdm_mic_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// pdm_mic_capture_ctrl_if
// Word-pair output handshake from the capture controller to decimation.
//   out_data0 : channel 0 word (bits sampled while pdm_clk is high)
//   out_data1 : channel 1 word (bits sampled while pdm_clk is low)
//   out_valid : word pair available
//   out_ready : consumer accepts the pair
// Modports: master (controller side), slave (consumer side).
// -----------------------------------------------------------------------------
interface pdm_mic_capture_ctrl_if #(
    parameter int WORD_BITS = 16
) ();
    logic [WORD_BITS-1:0] out_data0;
    logic [WORD_BITS-1:0] out_data1;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output out_data0,
        output out_data1,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data0,
        input  out_data1,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pdm_mic_capture_ctrl_clk_gen.sv
// -----------------------------------------------------------------------------
// pdm_clk_gen
// Phase counter and registered PDM clock, plus sample strobes.
//   clk, rst      : system clock, synchronous active-high reset
//   run_i         : controller will be in WAKE/RUN next cycle
//   pdm_clk_o     : registered PDM clock, high for phase < CLK_DIV/2
//   ch0_stb_o     : last high cycle of the PDM period (ch0 sample point)
//   ch1_stb_o     : last low cycle of the PDM period (ch1 sample point)
//   period_end_o  : period boundary (same cycle as ch1_stb_o)
// run_i is the controller's next-state view so that the first active cycle
// already shows phase 0 with pdm_clk high.
// -----------------------------------------------------------------------------
module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic pdm_clk_o,
    output logic ch0_stb_o,
    output logic ch1_stb_o,
    output logic period_end_o
);
    localparam int PW = cnt_width(CLK_DIV);
    localparam logic [PW-1:0] PH_ZERO = PW'(0);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] PH_CH0  = PW'(CLK_DIV / 2 - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic          run_q;
    logic          pdm_clk_q, pdm_clk_d;

    // Next phase: hold 0 when stopped or on the first active cycle, else wrap-count.
    always_comb begin
        phase_d = PH_ZERO;
        if (run_i && run_q) begin
            if (phase_q == PH_LAST) begin
                phase_d = PH_ZERO;
            end else begin
                phase_d = phase_q + PH_ONE;
            end
        end else begin
            phase_d = PH_ZERO;
        end
        pdm_clk_d = run_i && (phase_d < PH_HALF);
    end

    // Phase, run flag and PDM clock registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_ZERO;
            run_q     <= 1'b0;
            pdm_clk_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            run_q     <= run_i;
            pdm_clk_q <= pdm_clk_d;
        end
    end

    assign pdm_clk_o    = pdm_clk_q;
    assign ch0_stb_o    = run_q && (phase_q == PH_CH0);
    assign ch1_stb_o    = run_q && (phase_q == PH_LAST);
    assign period_end_o = run_q && (phase_q == PH_LAST);

endmodule

// File: rtl/pdm_mic_capture_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_mic_capture_ctrl
// Dual-microphone PDM capture: generates the PDM clock, waits for the mics to
// settle, captures ch0 (clock high) and ch1 (clock low) bits from the shared
// data line, packs them into words and offers word pairs downstream.
//   clk, rst      : system clock, synchronous active-high reset
//   enable        : run request (sampled at PDM period boundaries when active)
//   pdm_clk       : registered PDM clock to the microphones
//   pdm_data      : shared DDR data line, already synchronised to clk
//   out_if        : word-pair valid/ready handshake (master modport)
//   overflow      : sticky, set when a completed pair is dropped
//   overflow_clr  : clears overflow (a same-cycle drop wins)
//   busy          : high in WAKE and RUN
//   drop_cnt      : saturating dropped-pair count, present only when the
//                   PDM_DROP_CNT_EN macro is defined
// -----------------------------------------------------------------------------
module pdm_mic_capture_ctrl
    import pdm_pkg::*;
#(
    parameter int CLK_DIV     = 16,
    parameter int WORD_BITS   = 16,
    parameter int WAKE_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  pdm_clk,
    input  logic                  pdm_data,
    pdm_mic_capture_ctrl_if.master out_if,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic                  busy
`ifdef PDM_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);
    localparam int WW = cnt_width(WAKE_CYCLES);
    localparam int BW = cnt_width(WORD_BITS);
    localparam logic [WW-1:0] WAKE_ZERO = WW'(0);
    localparam logic [WW-1:0] WAKE_ONE  = WW'(1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);
    localparam logic [WORD_BITS-1:0] WORD_ZERO = WORD_BITS'(0);

    pdm_state_e           state_q, state_d;
    logic [WW-1:0]        wake_cnt_q, wake_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] sh0_q, sh0_d;
    logic [WORD_BITS-1:0] sh1_q, sh1_d;
    logic [WORD_BITS-1:0] dout0_q, dout0_d;
    logic [WORD_BITS-1:0] dout1_q, dout1_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
`ifdef PDM_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`endif

    logic run_s;
    logic ch0_stb_s;
    logic ch1_stb_s;
    logic period_end_s;
    logic word_done_s;
    logic drop_s;

    assign run_s = (state_d != ST_IDLE);

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_s),
        .pdm_clk_o    (pdm_clk),
        .ch0_stb_o    (ch0_stb_s),
        .ch1_stb_o    (ch1_stb_s),
        .period_end_o (period_end_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable only matters at period boundaries once active.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAKE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAKE: begin
                if (period_end_s) begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (wake_cnt_q == WAKE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAKE;
                    end
                end else begin
                    state_d = ST_WAKE;
                end
            end
            ST_RUN: begin
                if (period_end_s && !enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath logic: counters, shifters, output pair and flags.
    always_comb begin
        wake_cnt_d = wake_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sh0_d      = sh0_q;
        sh1_d      = sh1_q;
        dout0_d    = dout0_q;
        dout1_d    = dout1_q;
        valid_d    = valid_q;
        drop_s     = 1'b0;
        busy_d     = (state_d != ST_IDLE);

        // The final ch1 bit arrives in the boundary cycle itself, so it is
        // appended to the shifter contents when the word is handed off.
        word_done_s = (state_q == ST_RUN) && period_end_s && (bit_cnt_q == BIT_LAST);

        case (state_q)
            ST_IDLE: begin
                wake_cnt_d = WAKE_ZERO;
                bit_cnt_d  = BIT_ZERO;
                sh0_d      = WORD_ZERO;
                sh1_d      = WORD_ZERO;
            end
            ST_WAKE: begin
                if (period_end_s) begin
                    if (state_d == ST_WAKE) begin
                        wake_cnt_d = wake_cnt_q + WAKE_ONE;
                    end else begin
                        wake_cnt_d = WAKE_ZERO;
                    end
                end else begin
                    wake_cnt_d = wake_cnt_q;
                end
                bit_cnt_d = BIT_ZERO;
                sh0_d     = WORD_ZERO;
                sh1_d     = WORD_ZERO;
            end
            ST_RUN: begin
                if (ch0_stb_s) begin
                    sh0_d = {sh0_q[WORD_BITS-2:0], pdm_data};
                end else begin
                    sh0_d = sh0_q;
                end
                if (ch1_stb_s) begin
                    sh1_d = {sh1_q[WORD_BITS-2:0], pdm_data};
                end else begin
                    sh1_d = sh1_q;
                end
                if (period_end_s) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = BIT_ZERO;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
                // Leaving RUN throws away any partial word.
                if (state_d == ST_IDLE) begin
                    bit_cnt_d = BIT_ZERO;
                    sh0_d     = WORD_ZERO;
                    sh1_d     = WORD_ZERO;
                end else begin
                    wake_cnt_d = WAKE_ZERO;
                end
            end
            default: begin
                wake_cnt_d = WAKE_ZERO;
                bit_cnt_d  = BIT_ZERO;
                sh0_d      = WORD_ZERO;
                sh1_d      = WORD_ZERO;
            end
        endcase

        // A completing word loads only if the output slot is free or being
        // emptied this very cycle; otherwise the held pair wins.
        if (word_done_s) begin
            if (!valid_q || out_if.out_ready) begin
                dout0_d = sh0_q;
                dout1_d = {sh1_q[WORD_BITS-2:0], pdm_data};
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                drop_s  = 1'b1;
            end
        end else if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

`ifdef PDM_DROP_CNT_EN
        if (drop_s) begin
            if (overflow_clr) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else if (overflow_clr) begin
            drop_cnt_d = 16'd0;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wake_cnt_q <= WAKE_ZERO;
            bit_cnt_q  <= BIT_ZERO;
            sh0_q      <= WORD_ZERO;
            sh1_q      <= WORD_ZERO;
            dout0_q    <= WORD_ZERO;
            dout1_q    <= WORD_ZERO;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PDM_DROP_CNT_EN
            drop_cnt_q <= 16'd0;
`endif
        end else begin
            wake_cnt_q <= wake_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
`ifdef PDM_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign out_if.out_data0 = dout0_q;
    assign out_if.out_data1 = dout1_q;
    assign out_if.out_valid = valid_q;
    assign overflow         = ovf_q;
    assign busy             = busy_q;
`ifdef PDM_DROP_CNT_EN
    assign drop_cnt         = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pdm_mic_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdm_mic_capture_ctrl
// Directed bench for pdm_mic_capture_ctrl with CLK_DIV=4, WORD_BITS=8,
// WAKE_CYCLES=4. A microphone model drives the shared line per PDM period,
// the scenario pushes expected word pairs into a queue, and a monitor pops
// and compares on every accepted transfer. Honours PDM_DROP_CNT_EN.
// -----------------------------------------------------------------------------
module tb_pdm_mic_capture_ctrl;

    localparam int CLK_DIV = 4;
    localparam int WB      = 8;
    localparam int WAKE    = 4;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
    } pair_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic pdm_clk;
    logic pdm_data;
    logic overflow;
    logic overflow_clr;
    logic busy;
`ifdef PDM_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    pdm_mic_capture_ctrl_if #(.WORD_BITS(WB)) out_if ();

    pdm_mic_capture_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .WORD_BITS   (WB),
        .WAKE_CYCLES (WAKE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pdm_clk      (pdm_clk),
        .pdm_data     (pdm_data),
        .out_if       (out_if),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .busy         (busy)
`ifdef PDM_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    woff   = 0;
    pair_t exp_q[$];

    logic [7:0] wtab [0:15] = '{8'hB2, 8'h5A, 8'hC3, 8'h17, 8'hE8, 8'h69, 8'h3C, 8'hA5,
                                8'hD4, 8'h2B, 8'h96, 8'h71, 8'h0F, 8'hF0, 8'h81, 8'h7E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic pair_t word_pair(input int n);
        pair_t p;
        p.d0 = wtab[n % 16];
        p.d1 = ~wtab[n % 16];
        return p;
    endfunction

    // Mic model: period p (1-based since enable) carries bit (p-5) of the
    // word stream; the four settling periods carry 1s on both channels.
    function automatic logic gen_bit(input int p, input logic hi);
        int         n;
        int         i;
        logic [7:0] w;
        if (p < 5) begin
            return 1'b1;
        end
        n = (p - 5) / 8 + woff;
        i = (p - 5) % 8;
        w = wtab[n % 16];
        return hi ? w[7 - i] : ~w[7 - i];
    endfunction

    int   period    = 0;
    logic pclk_prev = 1'b0;

    always @(negedge clk) begin
        if (!enable) begin
            period = 0;
        end else if (pdm_clk && !pclk_prev) begin
            period = period + 1;
        end
        pclk_prev = pdm_clk;
        pdm_data  = gen_bit(period, pdm_clk);
    end

    // Monitor: compare accepted pairs with the scoreboard and check that a
    // held pair stays put.
    logic       hold_prev = 1'b0;
    logic [7:0] hold_d0   = 8'h00;
    logic [7:0] hold_d1   = 8'h00;
    pair_t      got;
    pair_t      want;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            got.d0 = out_if.out_data0;
            got.d1 = out_if.out_data1;
            if (hold_prev) begin
                check("hold_valid", 32'(out_if.out_valid), 32'd1);
                check("hold_data", 32'(got), 32'({hold_d0, hold_d1}));
            end
            if (out_if.out_valid && out_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_pair cyc=%0d got=%0h expected=none", cyc, got);
                end else begin
                    want = exp_q.pop_front();
                    check("pair", 32'(got), 32'(want));
                end
            end
            hold_prev = out_if.out_valid && !out_if.out_ready;
            hold_d0   = got.d0;
            hold_d1   = got.d1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic goto_c(input int c);
        while (cyc < c) begin
            step();
        end
    endtask

    task automatic start_run();
        enable = 1'b1;
        cyc    = -1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        enable           = 1'b0;
        overflow_clr     = 1'b0;
        out_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: nothing moves with enable low.
        for (int k = 0; k < 50; k++) begin
            step();
            check("idle_outs", 32'({pdm_clk, out_if.out_valid, busy, overflow}), 32'd0);
        end

        // Wake timing and word packing with a free-running consumer.
        exp_q.push_back(word_pair(0));
        exp_q.push_back(word_pair(1));
        exp_q.push_back(word_pair(2));
        start_run();
        check("busy_rise", 32'(busy), 32'd1);
        for (int c = 0; c < 16; c++) begin
            goto_c(c);
            check("wake_pdm_clk", 32'(pdm_clk), 32'(((c % 4) < 2) ? 1 : 0));
        end
        for (int c = 16; c <= 112; c++) begin
            goto_c(c);
            check("valid_pulse", 32'(out_if.out_valid),
                  32'(((c >= 48) && (((c - 48) % 32) == 0)) ? 1 : 0));
        end

        // Backpressure for two word times: word 3 held, word 4 dropped.
        goto_c(113);
        out_if.out_ready = 1'b0;
        exp_q.push_back(word_pair(3));
        goto_c(143);
        check("bp_valid_pre", 32'(out_if.out_valid), 32'd0);
        goto_c(144);
        check("bp_valid", 32'(out_if.out_valid), 32'd1);
        check("bp_data", 32'({out_if.out_data0, out_if.out_data1}), 32'(word_pair(3)));
        goto_c(175);
        check("ovf_pre", 32'(overflow), 32'd0);
        goto_c(176);
        check("ovf_set", 32'(overflow), 32'd1);
        check("drop_held", 32'({out_if.out_data0, out_if.out_data1}), 32'(word_pair(3)));
`ifdef PDM_DROP_CNT_EN
        check("drop_cnt_one", 32'(drop_cnt), 32'd1);
`endif
        goto_c(180);
        overflow_clr = 1'b1;
        goto_c(181);
        overflow_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
`ifdef PDM_DROP_CNT_EN
        check("drop_cnt_clr", 32'(drop_cnt), 32'd0);
`endif
        goto_c(190);
        out_if.out_ready = 1'b1;
        goto_c(191);
        out_if.out_ready = 1'b0;
        check("bp_release", 32'(out_if.out_valid), 32'd0);

        // Coincident transfer: accept word 5 on word 6's completion cycle.
        exp_q.push_back(word_pair(5));
        exp_q.push_back(word_pair(6));
        goto_c(207);
        check("co_valid_pre", 32'(out_if.out_valid), 32'd0);
        goto_c(208);
        check("co_data5", 32'({out_if.out_data0, out_if.out_data1}), 32'(word_pair(5)));
        goto_c(239);
        out_if.out_ready = 1'b1;
        goto_c(240);
        out_if.out_ready = 1'b0;
        check("co_valid", 32'(out_if.out_valid), 32'd1);
        check("co_data6", 32'({out_if.out_data0, out_if.out_data1}), 32'(word_pair(6)));
        check("co_no_ovf", 32'(overflow), 32'd0);
        goto_c(245);
        out_if.out_ready = 1'b1;
        goto_c(246);
        check("co_drain", 32'(out_if.out_valid), 32'd0);

        // Stop mid-word: enable drops during the 4th RUN bit of word 7.
        goto_c(253);
        enable = 1'b0;
        goto_c(255);
        check("stop_busy_boundary", 32'(busy), 32'd1);
        for (int c = 256; c < 276; c++) begin
            goto_c(c);
            check("stop_idle", 32'({busy, pdm_clk, out_if.out_valid}), 32'd0);
        end

        // Re-enable: full wake again, then a fresh word from period 5.
        woff = 8;
        exp_q.push_back(word_pair(8));
        start_run();
        check("re_busy", 32'(busy), 32'd1);
        for (int c = 1; c < 16; c++) begin
            goto_c(c);
            check("re_pdm_clk", 32'(pdm_clk), 32'(((c % 4) < 2) ? 1 : 0));
        end
        goto_c(47);
        check("re_valid_pre", 32'(out_if.out_valid), 32'd0);
        goto_c(48);
        check("re_valid", 32'(out_if.out_valid), 32'd1);

        // Reset mid-operation drops a pending pair.
        goto_c(49);
        out_if.out_ready = 1'b0;
        goto_c(80);
        check("rst_pending", 32'({out_if.out_valid, out_if.out_data0, out_if.out_data1}),
              32'({1'b1, word_pair(9)}));
        goto_c(85);
        rst = 1'b1;
        exp_q.delete();
        goto_c(86);
        rst    = 1'b0;
        enable = 1'b0;
        check("rst_outs", 32'({pdm_clk, out_if.out_valid, busy, overflow,
                               out_if.out_data0, out_if.out_data1}), 32'd0);
        goto_c(90);
        check("rst_stays_idle", 32'({pdm_clk, out_if.out_valid, busy}), 32'd0);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
